// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one external alu1 slice LSB-first, one bit per clock,
// chaining carry/borrow through a register and collecting the result in a shift register.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carry_in,
  output logic [2:0]       slice_select,
  input  logic             slice_out,
  input  logic             slice_carry_out
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  localparam logic [2:0] OpSub = 3'd2;
  localparam logic [2:0] OpAdd = 3'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= 3'd0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      carry_q      <= 1'b0;
      cnt_q        <= '0;
      result_q     <= '0;
      carry_flag_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a_in;
            b_q     <= b_in;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= {slice_out, res_q[WIDTH-1:1]};
          carry_q <= slice_carry_out;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            state_q      <= StDone;
            // The last bit is still in flight, so take it straight from the slice.
            result_q     <= {slice_out, res_q[WIDTH-1:1]};
            carry_flag_q <= ((op_q == OpAdd) || (op_q == OpSub)) & slice_carry_out;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    ready          = (state_q != StRun);
    busy           = (state_q == StRun);
    done           = (state_q == StDone);
    result         = result_q;
    carry_flag     = carry_flag_q;
    zero_flag      = (result_q == '0);
    // Slice inputs come only from registers, so there is no loop through the slice.
    slice_a        = busy & a_q[0];
    slice_b        = busy & b_q[0];
    slice_carry_in = busy & carry_q;
    slice_select   = op_q;
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: behavioural alu1 slice, word-level reference model checked every
// cycle, directed literal cases and randomized operations.
module tb_alu_serial_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ready, busy, done, carry_flag, zero_flag;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_carry_in, slice_out, slice_carry_out;
  logic [2:0]   slice_select;

  int n_assert = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .a_in            (a_in),
    .b_in            (b_in),
    .ready           (ready),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .carry_flag      (carry_flag),
    .zero_flag       (zero_flag),
    .slice_a         (slice_a),
    .slice_b         (slice_b),
    .slice_carry_in  (slice_carry_in),
    .slice_select    (slice_select),
    .slice_out       (slice_out),
    .slice_carry_out (slice_carry_out)
  );

  // One-bit alu1 slice.
  always_comb begin
    slice_out       = 1'b0;
    slice_carry_out = 1'b0;
    case (slice_select)
      3'd7: slice_out = slice_a & slice_b;
      3'd6: slice_out = ~slice_a;
      3'd5: slice_out = slice_a | slice_b;
      3'd4: slice_out = slice_a ^ slice_b;
      3'd3: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (slice_a & slice_b) | (slice_a & slice_carry_in) |
                          (slice_b & slice_carry_in);
      end
      3'd2: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (~slice_a & slice_b) | (~slice_a & slice_carry_in) |
                          (slice_b & slice_carry_in);
      end
      3'd1: slice_out = slice_a;
      default: slice_out = ~(slice_a ^ slice_b);
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level reference: {carry/borrow, result}.
  function automatic logic [W:0] ref_alu(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] s;
    case (o)
      3'd7: s = {1'b0, a & b};
      3'd6: s = {1'b0, ~a};
      3'd5: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      3'd3: s = {1'b0, a} + {1'b0, b};
      3'd2: s = {(a < b), W'(a - b)};
      3'd1: s = {1'b0, a};
      default: s = {1'b0, ~(a ^ b)};
    endcase
    return s;
  endfunction

  // Transaction model: an accepted op completes W clocks later.
  int         cyc = 0;
  int         done_at = -1;
  bit         m_rdy;
  logic       m_done = 1'b0;
  logic [W-1:0] m_res = '0;
  logic       m_cf = 1'b0;
  logic [2:0] m_op = 3'd0;
  logic [W:0] pend;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      done_at = -1;
      m_done  = 1'b0;
      m_res   = '0;
      m_cf    = 1'b0;
      m_op    = 3'd0;
    end else begin
      m_rdy  = (done_at < 0);
      m_done = 1'b0;
      if (done_at == cyc) begin
        m_done  = 1'b1;
        m_res   = pend[W-1:0];
        m_cf    = pend[W];
        done_at = -1;
      end
      if (start && m_rdy) begin
        m_op    = op;
        pend    = ref_alu(op, a_in, b_in);
        done_at = cyc + W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready, done_at < 0);
      chk("busy", busy, done_at >= 0);
      chk("done", done, m_done);
      chk("result", result, m_res);
      chk("carry_flag", carry_flag, m_cf);
      chk("zero_flag", zero_flag, m_res == '0);
      chk("slice_select", slice_select, m_op);
      if (done_at < 0) begin
        chk("slice_a_idle", slice_a, 1'b0);
        chk("slice_b_idle", slice_b, 1'b0);
        chk("slice_cin_idle", slice_carry_in, 1'b0);
      end
    end
  end

  // mode 0: quiet; 1: random start/operand noise during RUN; 2: start held during RUN.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode, output logic [W-1:0] r, output logic c,
                        output logic z, output int lat, output int nb);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    lat = -1; nb = 0; r = '0; c = 1'b0; z = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        lat = i; r = result; c = carry_flag; z = zero_flag;
        start = 1'b0;
        break;
      end
      if (mode != 0 && i <= 4) start = (mode == 2) ? 1'b1 : 1'($urandom % 2);
      else start = 1'b0;
      if (mode != 0) begin
        op = 3'($urandom); a_in = W'($urandom); b_in = W'($urandom);
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] r;
  logic         c, z;
  int           lat, nb, ndone;
  logic [2:0]   lop [6] = '{3'd7, 3'd5, 3'd4, 3'd0, 3'd6, 3'd1};
  logic [W-1:0] lexp [6] = '{4'h8, 4'hE, 4'h6, 4'h9, 4'h3, 4'hC};
  logic [2:0]   bop [4] = '{3'd3, 3'd2, 3'd7, 3'd4};
  logic [W-1:0] ba [4] = '{4'h7, 4'h3, 4'hC, 4'hC};
  logic [W-1:0] bb [4] = '{4'h9, 4'h5, 4'hA, 4'hA};
  logic [W-1:0] bexp [4] = '{4'h0, 4'hE, 4'h8, 4'h6};
  logic [W:0]   rr;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero_flag, 1);
    chk("rst_carry", carry_flag, 0);

    run_op(3'd3, 4'h7, 4'h9, 0, r, c, z, lat, nb);
    chk("add79_result", r, 4'h0);
    chk("add79_carry", c, 1);
    chk("add79_zero", z, 1);
    chk("add79_latency", lat, 5);
    chk("add79_busy_cycles", nb, 4);

    run_op(3'd2, 4'h3, 4'h5, 0, r, c, z, lat, nb);
    chk("sub35_result", r, 4'hE);
    chk("sub35_borrow", c, 1);
    run_op(3'd2, 4'h9, 4'h4, 0, r, c, z, lat, nb);
    chk("sub94_result", r, 4'h5);
    chk("sub94_borrow", c, 0);

    for (int k = 0; k < 6; k++) begin
      run_op(lop[k], 4'hC, 4'hA, 0, r, c, z, lat, nb);
      chk($sformatf("logic_op%0d_result", lop[k]), r, lexp[k]);
      chk($sformatf("logic_op%0d_carry", lop[k]), c, 0);
    end

    // Requests during RUN are ignored.
    run_op(3'd3, 4'h1, 4'h2, 2, r, c, z, lat, nb);
    chk("ignored_start_result", r, 4'h3);
    chk("ignored_start_latency", lat, 5);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_no_extra_done", ndone, 0);

    // Abort 2 cycles into ADD F+1.
    @(negedge clk);
    start = 1'b1; op = 3'd3; a_in = 4'hF; b_in = 4'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_result", result, 0);
    chk("abort_zero", zero_flag, 1);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(3'd3, 4'h5, 4'h6, 0, r, c, z, lat, nb);
    chk("after_abort_result", r, 4'hB);
    chk("after_abort_carry", c, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; op = bop[0]; a_in = ba[0]; b_in = bb[0];
    for (int k = 0; k < 4; k++) begin
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (done) begin
          lat = i;
          break;
        end
      end
      chk($sformatf("b2b%0d_interval", k), lat, 5);
      chk($sformatf("b2b%0d_result", k), result, bexp[k]);
      if (k < 3) begin
        op = bop[k+1]; a_in = ba[k+1]; b_in = bb[k+1];
      end else begin
        start = 1'b0;
      end
    end

    // Random operations with random gaps and noise during RUN.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ro, ra, rb, 1, r, c, z, lat, nb);
      rr = ref_alu(ro, ra, rb);
      chk("rand_result", r, rr[W-1:0]);
      chk("rand_carry", c, rr[W]);
      chk("rand_latency", lat, 5);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
